alu_serial: RTL and testbench

Bit-serial WIDTH-bit ALU that computes one bit per clock through a single 1-bit ALU slice, holding the carry in a flip-flop between bits. It sits directly upstream of the single-bit ALU slice and drives it: it decodes the 4-bit ALU control, feeds operand bits LSB-first, and collects the slice's result, carry and set outputs. It returns a full-width result plus zero, cout and overflow flags under a start/done handshake. It is the area-minimal alternative to the ripple-carry array in the execute stage.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_bit_slice.sv | 35 +++
 rtl/alu_serial.sv | 135 +++++++++++++
 tb/tb_alu_serial.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and defaults for the bit-serial ALU
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice (invert, AND/OR/ADD/LESS)
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic [1:0] operation,
    input  logic       cin,
    input  logic       less,
    output logic       result,
    output logic       cout,
    output logic       set
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff = a ^ a_invert;
    assign b_eff = b ^ b_invert;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
    assign set   = sum;

    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - bit-serial ALU, one bit per clock; ALU_SLT_OVF_FIX_EN selects overflow-corrected SLT
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_e           state;
    state_e           state_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       ctrl_sh;
    logic [WIDTH-2:0] res_sh;

    logic             s_res;
    logic             s_cout;
    logic             s_set;
    logic             accept;
    logic             slt_bit;
    logic [WIDTH-1:0] full_bits;
    logic [WIDTH-1:0] final_res;
    logic             final_cout;
    logic             final_ovf;

    alu_bit_slice u_slice (
        .a         (a_sh[idx]),
        .b         (b_sh[idx]),
        .a_invert  (ctrl_sh[3]),
        .b_invert  (ctrl_sh[2]),
        .operation (ctrl_sh[1:0]),
        .cin       (carry),
        .less      (1'b0),
        .result    (s_res),
        .cout      (s_cout),
        .set       (s_set)
    );

    assign accept = start && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // carry still holds the carry into the MSB while the last bit is in the slice
    always_comb begin
`ifdef ALU_SLT_OVF_FIX_EN
        slt_bit = s_set ^ (carry ^ s_cout);
`else
        slt_bit = s_set;
`endif
        full_bits  = {s_res, res_sh};
        final_res  = '0;
        final_cout = 1'b0;
        final_ovf  = 1'b0;
        case (ctrl_sh)
            ALU_AND, ALU_OR, ALU_NOR: final_res = full_bits;
            ALU_ADD, ALU_SUB: begin
                final_res  = full_bits;
                final_cout = s_cout;
                final_ovf  = carry ^ s_cout;
            end
            ALU_SLT: begin
                final_res  = {{(WIDTH-1){1'b0}}, slt_bit};
                final_cout = s_cout;
            end
            default: final_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            ctrl_sh  <= '0;
            res_sh   <= '0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh    <= src1;
            b_sh    <= src2;
            ctrl_sh <= ALU_control;
            idx     <= '0;
            carry   <= ALU_control[2];
        end else if (state == ST_RUN) begin
            res_sh <= full_bits[WIDTH-1:1];
            carry  <= s_cout;
            idx    <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                result   <= final_res;
                zero     <= (final_res == '0);
                cout     <= final_cout;
                overflow <= final_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - self-checking bench for alu_serial (vectors, random ops vs model, handshake corners)
module tb_alu_serial;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALU_control;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_z;
        logic         exp_c;
        logic         exp_o;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, {result, zero, cout, overflow}
    function automatic logic [W+2:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W:0]   d;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        s  = {1'b0, a} + {1'b0, b};
        d  = {1'b0, a} + {1'b0, ~b} + 1;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                r  = s[W-1:0];
                co = s[W];
                ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'b0110: begin
                r  = d[W-1:0];
                co = d[W];
                ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
            end
            4'b0111: begin
`ifdef ALU_SLT_OVF_FIX_EN
                r = ($signed(a) < $signed(b)) ? 1 : 0;
`else
                r = {{(W-1){1'b0}}, d[W-1]};
`endif
                co = d[W];
            end
            default: r = '0;
        endcase
        return {r, (r == '0), co, ov};
    endfunction

    task automatic do_accept(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start       = 1'b1;
        ALU_control = c;
        src1        = a;
        src2        = b;
        @(negedge clk);
        start       = 1'b0;
        ALU_control = 4'($urandom);
        src1        = $urandom;
        src2        = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < W + 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[$];
    int   lat;
    int   ndone;
    logic [W+2:0] m;
    logic [3:0]   rc;
    logic [3:0]   ctrl_pool[7];

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        ALU_control = '0;
        src1        = '0;
        src2        = '0;

        vecs.push_back('{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'b0111, 32'h0000_0003, 32'h0000_0007, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b0111, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
`ifdef ALU_SLT_OVF_FIX_EN
        vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0});
`else
        vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
`endif
        vecs.push_back('{4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {29'b0, zero, cout, overflow}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_accept(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            chk("vec_busy", {31'b0, busy}, 1);
            wait_done(lat);
            chk("vec_latency", 32'(lat), 32'(W));
            chk("vec_result", result, vecs[i].exp_r);
            chk("vec_flags", {29'b0, zero, cout, overflow},
                {29'b0, vecs[i].exp_z, vecs[i].exp_c, vecs[i].exp_o});
        end

        ctrl_pool = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            rc = ctrl_pool[$urandom_range(0, 6)];
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            m  = model(rc, a, b);
            do_accept(rc, a, b);
            wait_done(lat);
            chk("rand_op", result, m[W+2:3]);
            chk("rand_flags", {29'b0, zero, cout, overflow}, {29'b0, m[2:0]});
        end

        // start during RUN must be ignored
        do_accept(4'b0010, 32'h1234_5678, 32'h1111_1111);
        repeat (4) @(negedge clk);
        start = 1'b1; ALU_control = 4'b0110; src1 = 32'hDEAD_BEEF; src2 = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignore_latency", 32'(lat + 5), 32'(W));
        chk("ignore_result", result, 32'h2345_6789);

        // reset in mid-RUN discards the operation
        do_accept(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {31'b0, busy}, 0);
        chk("midreset_result", result, 0);
        chk("midreset_done", {31'b0, done}, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", 32'(ndone), 0);

        // back-to-back: start presented while in DONE
        do_accept(4'b0010, 32'h0000_0005, 32'h0000_0006);
        wait_done(lat);
        chk("b2b_first", result, 32'h0000_000B);
        start = 1'b1; ALU_control = 4'b0010; src1 = 32'h1; src2 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 1);
        wait_done(lat);
        chk("b2b_gap", 32'(lat + 1), 32'(W + 1));
        chk("b2b_result", result, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
